// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Takes one instruction per valid/ready handshake. Aligned loads and stores are
// issued on a 64-bit req/ack data port. Misaligned, upstream and timeout faults
// are folded into the result. Writeback sees a registered pulse, one cycle wide.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] sdata,
  input  logic        wen_i,
  input  logic [4:0]  rd_i,
  input  logic [63:0] wdata_i,
  input  logic        csr_wen_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic        exception_i,
  input  logic [63:0] pc_i,
  input  logic [63:0] mcause_i,
  output logic        dmem_req,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_wstrb,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wen_o,
  output logic [4:0]  rd_o,
  output logic [63:0] wdata_o,
  output logic        csr_wen_o,
  output logic [11:0] csr_addr_o,
  output logic [63:0] csr_wdata_o,
  output logic        exception_o,
  output logic [63:0] pc_o,
  output logic [63:0] mcause_o
);

  // state  | meaning
  // S_IDLE | accepting; bypass instructions complete from here in one cycle
  // S_WAIT | aligned access issued, dmem_req held until ack or timeout

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Timeout is a down-counter loaded on entry to WAIT; expiry when it reaches
  // zero with no ack gives exactly TIMEOUT_CYCLES WAIT cycles.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LOAD =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  logic             ld_q;
  logic [2:0]       funct3_q;
  logic [2:0]       off_q;
  logic             wen_q;
  logic [4:0]       rd_q;
  logic [63:0]      wdata_q;
  logic             csr_wen_q;
  logic [11:0]      csr_addr_q;
  logic [63:0]      csr_wdata_q;
  logic [63:0]      pc_q;
  logic [63:0]      mcause_q;

  logic [2:0]       off;
  logic [7:0]       size_mask;
  logic             misaligned;
  logic             is_mem;
  logic [63:0]      lane;
  logic [63:0]      load_val;

  assign off      = addr[2:0];
  assign is_mem   = mem_ren | mem_wen;
  assign in_ready = (state == S_IDLE);
  assign to_hit   = TO_EN && (to_cnt == '0);

  // Access size from funct3: byte-lane mask and natural-alignment check.
  always_comb begin
    size_mask  = 8'h01;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        size_mask  = 8'h01;
        misaligned = 1'b0;
      end
      2'b01: begin
        size_mask  = 8'h03;
        misaligned = addr[0];
      end
      2'b10: begin
        size_mask  = 8'h0F;
        misaligned = |addr[1:0];
      end
      default: begin
        size_mask  = 8'hFF;
        misaligned = |addr[2:0];
      end
    endcase
  end

  // Load path: move the addressed lane to bit 0, then sign- or zero-extend.
  always_comb begin
    lane     = dmem_rdata >> {off_q, 3'b000};
    load_val = lane;
    case (funct3_q)
      3'b000:  load_val = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_val = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_val = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_val = {56'd0, lane[7:0]};
      3'b101:  load_val = {48'd0, lane[15:0]};
      3'b110:  load_val = {32'd0, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  // Sequencer: accept and classify instructions, run the dmem handshake,
  // and publish one-cycle results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      dmem_req    <= 1'b0;
      dmem_addr   <= '0;
      dmem_wstrb  <= '0;
      dmem_wdata  <= '0;
      wen_o       <= 1'b0;
      rd_o        <= '0;
      wdata_o     <= '0;
      csr_wen_o   <= 1'b0;
      csr_addr_o  <= '0;
      csr_wdata_o <= '0;
      exception_o <= 1'b0;
      pc_o        <= '0;
      mcause_o    <= '0;
      ld_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      wen_q       <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      csr_wen_q   <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      pc_q        <= '0;
      mcause_q    <= '0;
    end else begin
      // Bubble unless a result is published below; data fields just hold.
      wen_o       <= 1'b0;
      csr_wen_o   <= 1'b0;
      exception_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (exception_i) begin
              rd_o        <= rd_i;
              wdata_o     <= wdata_i;
              csr_addr_o  <= csr_addr_i;
              csr_wdata_o <= csr_wdata_i;
              pc_o        <= pc_i;
              mcause_o    <= mcause_i;
              exception_o <= 1'b1;
            end else if (is_mem && misaligned) begin
              rd_o        <= rd_i;
              wdata_o     <= wdata_i;
              csr_addr_o  <= csr_addr_i;
              csr_wdata_o <= csr_wdata_i;
              pc_o        <= pc_i;
              mcause_o    <= mem_ren ? 64'd4 : 64'd6;
              exception_o <= 1'b1;
            end else if (is_mem) begin
              state       <= S_WAIT;
              to_cnt      <= TO_LOAD;
              dmem_req    <= 1'b1;
              dmem_addr   <= {addr[63:3], 3'b000};
              dmem_wstrb  <= mem_ren ? 8'h00 : (size_mask << off);
              dmem_wdata  <= mem_ren ? 64'd0 : (sdata << {off, 3'b000});
              ld_q        <= mem_ren;
              funct3_q    <= funct3;
              off_q       <= off;
              wen_q       <= wen_i;
              rd_q        <= rd_i;
              wdata_q     <= wdata_i;
              csr_wen_q   <= csr_wen_i;
              csr_addr_q  <= csr_addr_i;
              csr_wdata_q <= csr_wdata_i;
              pc_q        <= pc_i;
              mcause_q    <= mcause_i;
            end else begin
              wen_o       <= wen_i & (rd_i != 5'd0);
              rd_o        <= rd_i;
              wdata_o     <= wdata_i;
              csr_wen_o   <= csr_wen_i;
              csr_addr_o  <= csr_addr_i;
              csr_wdata_o <= csr_wdata_i;
              pc_o        <= pc_i;
              mcause_o    <= mcause_i;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            // Ack beats a timeout expiring on the same edge.
            state       <= S_IDLE;
            dmem_req    <= 1'b0;
            wen_o       <= ld_q & wen_q & (rd_q != 5'd0);
            rd_o        <= rd_q;
            wdata_o     <= ld_q ? load_val : wdata_q;
            csr_wen_o   <= csr_wen_q;
            csr_addr_o  <= csr_addr_q;
            csr_wdata_o <= csr_wdata_q;
            pc_o        <= pc_q;
            mcause_o    <= mcause_q;
          end else if (to_hit) begin
            state       <= S_IDLE;
            dmem_req    <= 1'b0;
            rd_o        <= rd_q;
            wdata_o     <= wdata_q;
            csr_addr_o  <= csr_addr_q;
            csr_wdata_o <= csr_wdata_q;
            pc_o        <= pc_q;
            mcause_o    <= ld_q ? 64'd5 : 64'd7;
            exception_o <= 1'b1;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
